key_click_decode: RTL and testbench

KEY_CLICK_DECODE -- requirements
Module: key_click_decode

---
 rtl/key_click_if.sv | 23 ++
 rtl/key_click_decode.sv | 122 ++++++++++++
 tb/tb_key_click_decode.sv | 130 +++++++++++++
 3 files changed

// File: rtl/key_click_if.sv
// Key click decoder bus: debounced press pulse in, click report and busy flag out.
interface key_click_if;
    logic       key_flag;
    logic       click_valid;
    logic [1:0] click_num;
    logic       busy;

    // Upstream side: drives key presses and observes reports.
    modport master (
        output key_flag,
        input  click_valid,
        input  click_num,
        input  busy
    );

    // Decoder side.
    modport slave (
        input  key_flag,
        output click_valid,
        output click_num,
        output busy
    );
endinterface

// File: rtl/key_click_decode.sv
// Counts debounced key presses inside a sliding window and reports single,
// double or triple clicks. The window restarts on every press; reaching
// MAX_CLICKS reports immediately, otherwise the count is reported on expiry.
module key_click_decode #(
    parameter logic [23:0] WIN_MAX    = 24'd9_999_999,
    parameter logic [1:0]  MAX_CLICKS = 2'd3
) (
    input logic         sys_clk,
    input logic         sys_rst,
    key_click_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic [23:0] win_cnt_q, win_cnt_d;
    logic [1:0]  clicks_q, clicks_d;
    logic        click_valid_q, click_valid_d;
    logic [1:0]  click_num_q, click_num_d;
    logic        busy_q, busy_d;

    // Widened so clicks+1 cannot wrap when compared against MAX_CLICKS.
    logic [2:0]  clicks_inc;
    logic        last_click;
    logic        win_done;

    assign clicks_inc = {1'b0, clicks_q} + 3'd1;
    assign last_click = (clicks_inc >= {1'b0, MAX_CLICKS});
    assign win_done   = (win_cnt_q == WIN_MAX);

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a press always takes priority over window expiry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.key_flag && (MAX_CLICKS > 2'd1)) state_d = StWait;
            end
            StWait: begin
                if (bus.key_flag) begin
                    if (last_click) state_d = StIdle;
                end else if (win_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        win_cnt_d     = win_cnt_q;
        clicks_d      = clicks_q;
        click_valid_d = 1'b0;
        click_num_d   = click_num_q;
        unique case (state_q)
            StIdle: begin
                if (bus.key_flag) begin
                    if (MAX_CLICKS > 2'd1) begin
                        win_cnt_d = '0;
                        clicks_d  = 2'd1;
                    end else begin
                        click_valid_d = 1'b1;
                        click_num_d   = 2'd1;
                    end
                end
            end
            StWait: begin
                if (bus.key_flag) begin
                    if (last_click) begin
                        click_valid_d = 1'b1;
                        click_num_d   = MAX_CLICKS;
                        win_cnt_d     = '0;
                        clicks_d      = '0;
                    end else begin
                        clicks_d  = clicks_inc[1:0];
                        win_cnt_d = '0;
                    end
                end else if (win_done) begin
                    click_valid_d = 1'b1;
                    click_num_d   = clicks_q;
                    win_cnt_d     = '0;
                    clicks_d      = '0;
                end else begin
                    win_cnt_d = win_cnt_q + 24'd1;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == StWait);
    end

    // Datapath and output registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            win_cnt_q     <= '0;
            clicks_q      <= '0;
            click_valid_q <= 1'b0;
            click_num_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            win_cnt_q     <= win_cnt_d;
            clicks_q      <= clicks_d;
            click_valid_q <= click_valid_d;
            click_num_q   <= click_num_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.click_valid = click_valid_q;
    assign bus.click_num   = click_num_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_key_click_decode.sv
// Scoreboard bench for key_click_decode with a 20-cycle window.
module tb_key_click_decode;

    localparam logic [23:0] WinMax    = 24'd19;
    localparam logic [1:0]  MaxClicks = 2'd3;

    typedef struct {
        int cyc;
        int num;
    } exp_t;

    logic sys_clk;
    logic sys_rst;
    int   edge_no;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    key_click_if bus ();

    key_click_decode #(
        .WIN_MAX    (WinMax),
        .MAX_CLICKS (MaxClicks)
    ) u_dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Index of the most recent rising edge.
    always @(posedge sys_clk) edge_no <= edge_no + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    // Every report must match the oldest pending expectation in cycle and count.
    always @(negedge sys_clk) begin
        if (bus.click_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_report", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("report_edge", edge_no, e.cyc);
                check_eq("report_num", int'(bus.click_num), e.num);
            end
        end
    end

    // Drive presses at t+i for each set bit i, t being the next rising edge.
    // Expected reports are queued as stimulus starts; off2 < 0 means none.
    task automatic run_seq(input logic [63:0] presses, input int off1, input int num1,
                           input int off2, input int num2, input int len);
        int t;
        exp_t e;
        t = edge_no + 1;
        e.cyc = t + off1;
        e.num = num1;
        exp_q.push_back(e);
        if (off2 >= 0) begin
            e.cyc = t + off2;
            e.num = num2;
            exp_q.push_back(e);
        end
        for (int i = 0; i < len; i++) begin
            bus.key_flag = (i < 64) ? presses[i] : 1'b0;
            if (edge_no == t) check_eq("busy_after_press", int'(bus.busy), 1);
            if (edge_no == t + off1) check_eq("busy_after_report", int'(bus.busy), 0);
            @(negedge sys_clk);
        end
        bus.key_flag = 1'b0;
        check_eq("num_hold", int'(bus.click_num), (off2 >= 0) ? num2 : num1);
        check_eq("pending_reports", exp_q.size(), 0);
    endtask

    initial begin
        int t;
        checks       = 0;
        failures     = 0;
        edge_no      = 0;
        sys_rst      = 1'b1;
        bus.key_flag = 1'b0;

        // Reset held with the key toggling.
        repeat (3) begin
            @(negedge sys_clk);
            bus.key_flag = ~bus.key_flag;
            check_eq("rst_valid", int'(bus.click_valid), 0);
            check_eq("rst_num", int'(bus.click_num), 0);
            check_eq("rst_busy", int'(bus.busy), 0);
        end
        @(negedge sys_clk);
        bus.key_flag = 1'b0;
        sys_rst      = 1'b0;

        // Single, double, triple (early), boundary press on expiry, back-to-back.
        run_seq(64'h1, 20, 1, -1, 0, 26);
        run_seq(64'h401, 30, 2, -1, 0, 36);
        run_seq(64'h421, 10, 3, -1, 0, 40);
        run_seq(64'h10_0001, 40, 2, -1, 0, 46);
        run_seq(64'hC21, 10, 3, 31, 1, 40);

        // Reset in the middle of an open window.
        t = edge_no + 1;
        bus.key_flag = 1'b1;
        @(negedge sys_clk);
        bus.key_flag = 1'b0;
        check_eq("mid_busy_before", int'(bus.busy), 1);
        while (edge_no < t + 7) @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        #1 check_eq("mid_rst_busy", int'(bus.busy), 0);
        check_eq("mid_rst_valid", int'(bus.click_valid), 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        while (edge_no < t + 29) @(negedge sys_clk);
        run_seq(64'h1, 20, 1, -1, 0, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
